// File: rtl/whack_pkg.sv
// whack_pkg: shared constants, FSM state type and LFSR helper for the mole game.
package whack_pkg;

    localparam int unsigned NUM_HOLES         = 5;
    localparam int unsigned LFSR_W            = 16;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GAP       = 3'd1,
        SPAWN     = 3'd2,
        DWELL     = 3'd3,
        END_CHECK = 3'd4,
        DONE      = 3'd5
    } state_t;

    // One step of the right-shifting Galois LFSR, x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// mole_lfsr: free-running 16-bit LFSR and the mole pattern derived from it.
// The pattern is never zero and carries at most MAX_MOLES set bits.
module mole_lfsr #(
    parameter int unsigned HOLES     = whack_pkg::NUM_HOLES,
    parameter int unsigned MAX_MOLES = 2,
    parameter logic [15:0] SEED      = whack_pkg::LFSR_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    output logic [HOLES-1:0] pattern_c
);
    import whack_pkg::*;

    logic [15:0]      lfsr;
    logic [HOLES-1:0] cand;
    int unsigned      kept;

    // LFSR advances every clock regardless of game state.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    // Zero fix-up from the index field above the candidate, then keep the lowest set bits.
    always_comb begin
        cand      = lfsr[HOLES-1:0];
        kept      = 0;
        pattern_c = '0;
        if (cand == '0) begin
            cand = HOLES'(1) << (32'(lfsr[HOLES+2:HOLES]) % HOLES);
        end
        for (int i = 0; i < int'(HOLES); i++) begin
            if (cand[i] && (kept < MAX_MOLES)) begin
                pattern_c[i] = 1'b1;
                kept         = kept + 32'd1;
            end
        end
    end

endmodule

// File: rtl/mole_spawner.sv
// mole_spawner: sequences a game of ROUNDS rounds, loading random mole patterns
// into the board, ending rounds early when cleared and flagging expired misses.
// Optional MOLE_SPAWNER_SPEEDUP_EN: dwell shortens every fifth round down to a floor.
module mole_spawner #(
    parameter int unsigned NUM_HOLES    = whack_pkg::NUM_HOLES,
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES   = 12500000,
    parameter int unsigned MAX_MOLES    = 2,
    parameter int unsigned ROUNDS       = 30,
    parameter logic [15:0] LFSR_SEED    = whack_pkg::LFSR_SEED_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [NUM_HOLES-1:0] board_state,
    output logic                 load,
    output logic [NUM_HOLES-1:0] loadval,
    output logic                 miss_trigger,
    output logic [7:0]           round,
    output logic                 busy,
    output logic                 done
);
    import whack_pkg::*;

    localparam int unsigned MAX_SPAN = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int unsigned TIMER_W  = (MAX_SPAN > 1) ? $clog2(MAX_SPAN) : 1;

    state_t               state;
    state_t               next_state;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_d;
    logic                 load_d;
    logic [NUM_HOLES-1:0] loadval_d;
    logic                 miss_d;
    logic [7:0]           round_d;
    logic                 busy_d;
    logic                 done_d;
    logic [NUM_HOLES-1:0] pattern_c;
    logic                 gap_last;
    logic                 dwell_last;
    logic                 dwell_first;
    logic                 board_clear;
    logic                 dwell_exit;
    logic                 dwell_miss;
    logic                 round_full;

    mole_lfsr #(
        .HOLES     (NUM_HOLES),
        .MAX_MOLES (MAX_MOLES),
        .SEED      (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .pattern_c (pattern_c)
    );

`ifdef MOLE_SPAWNER_SPEEDUP_EN
    localparam int unsigned LIM_W       = $clog2(DWELL_CYCLES + 1);
    localparam int unsigned SPEED_STEP  = DWELL_CYCLES / 16;
    localparam int unsigned SPEED_FLOOR = DWELL_CYCLES / 4;

    logic [LIM_W-1:0] dwell_lim;
    logic [LIM_W-1:0] dwell_lim_d;

    // Effective dwell limit, shortened at every fifth completed round.
    always_comb begin
        dwell_lim_d = dwell_lim;
        if (((state == IDLE) || (state == DONE)) && start) begin
            dwell_lim_d = LIM_W'(DWELL_CYCLES);
        end else if ((state == END_CHECK) && (round != 8'd0) && ((round % 8'd5) == 8'd0)) begin
            dwell_lim_d = (32'(dwell_lim) >= SPEED_FLOOR + SPEED_STEP)
                        ? dwell_lim - LIM_W'(SPEED_STEP)
                        : LIM_W'(SPEED_FLOOR);
        end
    end

    // Dwell limit register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_lim <= LIM_W'(DWELL_CYCLES);
        end else begin
            dwell_lim <= dwell_lim_d;
        end
    end

    assign dwell_last = ((32'(timer) + 32'd1) == 32'(dwell_lim));
`else
    assign dwell_last = ((32'(timer) + 32'd1) == DWELL_CYCLES);
`endif

    // The first dwell cycle sees the previous board, so only expiry counts there.
    assign gap_last    = ((32'(timer) + 32'd1) == GAP_CYCLES);
    assign dwell_first = (timer == '0);
    assign board_clear = (board_state == '0);
    assign dwell_exit  = dwell_last || (!dwell_first && board_clear);
    assign dwell_miss  = dwell_last && (dwell_first || !board_clear);
    assign round_full  = (32'(round) == ROUNDS);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE, DONE: if (start)      next_state = GAP;
            GAP:        if (gap_last)   next_state = SPAWN;
            SPAWN:                      next_state = DWELL;
            DWELL:      if (dwell_exit) next_state = END_CHECK;
            END_CHECK:                  next_state = round_full ? DONE : GAP;
            default:                    next_state = IDLE;
        endcase
    end

    // Output and datapath actions taken on leaving each state.
    always_comb begin
        load_d    = 1'b0;
        miss_d    = 1'b0;
        loadval_d = loadval;
        round_d   = round;
        busy_d    = busy;
        done_d    = done;
        timer_d   = timer;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    timer_d = '0;
                    round_d = 8'd0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            GAP: begin
                timer_d = timer + TIMER_W'(1);
            end
            SPAWN: begin
                load_d    = 1'b1;
                loadval_d = pattern_c;
                timer_d   = '0;
            end
            DWELL: begin
                timer_d = timer + TIMER_W'(1);
                if (dwell_exit) begin
                    round_d = (round == 8'hFF) ? round : round + 8'd1;
                end
                if (dwell_miss) begin
                    miss_d    = 1'b1;
                    load_d    = 1'b1;
                    loadval_d = '0;
                end
            end
            END_CHECK: begin
                if (round_full) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    timer_d = '0;
                end
            end
            default: begin
                timer_d = '0;
            end
        endcase
    end

    // Registered outputs and timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            load         <= 1'b0;
            loadval      <= '0;
            miss_trigger <= 1'b0;
            round        <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timer        <= '0;
        end else begin
            load         <= load_d;
            loadval      <= loadval_d;
            miss_trigger <= miss_d;
            round        <= round_d;
            busy         <= busy_d;
            done         <= done_d;
            timer        <= timer_d;
        end
    end

endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: randomized games against a cycle-stamped event model of the spawner.
module tb_mole_spawner;

    localparam int unsigned HOLES = 5;
    localparam int unsigned GAP   = 4;
    localparam int unsigned MAXM  = 2;
    localparam logic [15:0] SEED  = 16'hACE1;
`ifdef MOLE_SPAWNER_SPEEDUP_EN
    localparam int unsigned DWELL   = 64;
    localparam int unsigned NROUNDS = 12;
`else
    localparam int unsigned DWELL   = 20;
    localparam int unsigned NROUNDS = 3;
`endif

    typedef struct {
        int         cyc;
        logic [4:0] val;
        logic       miss;
        logic [7:0] rnd;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] board_state;
    logic       load;
    logic [4:0] loadval;
    logic       miss_trigger;
    logic [7:0] round;
    logic       busy;
    logic       done;

    logic [4:0] pat_a, pat_b, pat_c, pat_d;

    exp_t        sb_q[$];
    int          n_vec  = 0;
    int          n_err  = 0;
    int          cyc    = 0;
    int          hit_at = -1;
    logic [15:0] m_lfsr = SEED;
    logic        prev_load = 1'b0;

    mole_spawner #(
        .NUM_HOLES    (HOLES),
        .DWELL_CYCLES (DWELL),
        .GAP_CYCLES   (GAP),
        .MAX_MOLES    (MAXM),
        .ROUNDS       (NROUNDS),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .board_state  (board_state),
        .load         (load),
        .loadval      (loadval),
        .miss_trigger (miss_trigger),
        .round        (round),
        .busy         (busy),
        .done         (done)
    );

    // Pattern generators pinned at chosen LFSR values (held in reset).
    mole_lfsr #(.HOLES(5), .MAX_MOLES(2), .SEED(16'h001F)) u_fix_a (.clk(clk), .rst(1'b1), .pattern_c(pat_a));
    mole_lfsr #(.HOLES(5), .MAX_MOLES(2), .SEED(16'h00C0)) u_fix_b (.clk(clk), .rst(1'b1), .pattern_c(pat_b));
    mole_lfsr #(.HOLES(5), .MAX_MOLES(2), .SEED(16'h0015)) u_fix_c (.clk(clk), .rst(1'b1), .pattern_c(pat_c));
    mole_lfsr #(.HOLES(5), .MAX_MOLES(2), .SEED(16'h00E0)) u_fix_d (.clk(clk), .rst(1'b1), .pattern_c(pat_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        // x^16+x^14+x^13+x^11+1, Galois form shifting right
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [4:0] ref_pattern(input logic [15:0] v);
        logic [4:0] c;
        logic [4:0] r;
        int         n;
        c = v[4:0];
        if (c == 5'd0) c = 5'(1 << (int'(v[7:5]) % 5));
        r = 5'd0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (c[i] && n < int'(MAXM)) begin
                r[i] = 1'b1;
                n++;
            end
        end
        return r;
    endfunction

    // Cycle counter and reference LFSR track every clock edge.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        if (cyc > c) begin
            n_vec++;
            n_err++;
            $display("FAIL model_late: at cycle %0d expected to be at %0d", cyc, c);
        end
        while (cyc < c) tick();
    endtask

    // Board mimic: takes loadval one cycle after load, and zeros at the scheduled hit cycle.
    initial begin : board
        logic       pl;
        logic [4:0] pv;
        pl = 1'b0;
        pv = 5'd0;
        board_state = 5'd0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                board_state = 5'd0;
                pl = 1'b0;
            end else begin
                if (pl) board_state = pv;
                if (cyc == hit_at) board_state = 5'd0;
                pl = load;
                pv = loadval;
            end
        end
    end

    // Monitor: every load/miss presented by the DUT is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (load || miss_trigger) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: load=%0b loadval=%b miss=%0b at cycle %0d, nothing expected",
                         load, loadval, miss_trigger, cyc);
            end else begin
                e = sb_q.pop_front();
                check("event_cycle", 32'(cyc), 32'(e.cyc));
                check("event_load", 32'(load), 32'd1);
                check("event_loadval", 32'(loadval), 32'(e.val));
                check("event_miss", 32'(miss_trigger), 32'(e.miss));
                check("event_round", 32'(round), 32'(e.rnd));
                check("load_not_back_to_back", 32'(prev_load), 32'd0);
            end
        end
        prev_load = load;
    end

    // mode 0: never hit, 1: hit 2 cycles after load, 2: random, 3: alternate at/after expiry
    task automatic play_game(input int mode, input bit poke_start, input bit poke_rst);
        int         s, l, t, hz, lim;
        bit         cleared;
        logic [4:0] pat;
        start = 1'b1;
        s = cyc + 1;
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_round", 32'(round), 32'd0);
        lim = int'(DWELL);
        l = s + int'(GAP) + 1;
        for (int r = 1; r <= int'(NROUNDS); r++) begin
            wait_until(l - 1);
            pat = ref_pattern(m_lfsr);
            case (mode)
                0:       hz = -1;
                1:       hz = 2;
                2:       hz = int'($urandom_range(32'(lim + 2), 32'd2));
                default: hz = (r % 2 == 1) ? lim - 1 : lim;
            endcase
            cleared = (hz >= 2) && (hz <= lim - 1);
            t = cleared ? hz : lim - 1;
            hit_at = (hz < 0) ? -1 : l + hz;
            sb_q.push_back('{l, pat, 1'b0, 8'(r - 1)});
            if (!cleared) sb_q.push_back('{l + lim, 5'd0, 1'b1, 8'(r)});
            if (poke_start && r == 2) begin
                wait_until(l + 3);
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (poke_rst && r == 1) begin
                wait_until(l + 5);
                rst = 1'b1;
                tick();
                sb_q.delete();
                hit_at = -1;
                check("reset_mid_dwell_outputs",
                      {16'd0, load, loadval, miss_trigger, round, busy, done}, 32'd0);
                rst = 1'b0;
                return;
            end
            wait_until(l + t + 1);
            check("round_after_exit", 32'(round), 32'(r));
            check("busy_during_game", 32'(busy), 32'd1);
            if (r == int'(NROUNDS)) begin
                wait_until(l + t + 2);
                check("game_done", 32'(done), 32'd1);
                check("game_not_busy", 32'(busy), 32'd0);
                check("game_round", 32'(round), 32'(NROUNDS));
            end
`ifdef MOLE_SPAWNER_SPEEDUP_EN
            if (r % 5 == 0) lim = (lim - int'(DWELL / 16) > int'(DWELL / 4)) ? lim - int'(DWELL / 16) : int'(DWELL / 4);
`endif
            l = l + t + int'(GAP) + 3;
        end
        repeat (5) tick();
        check("done_held", 32'(done), 32'd1);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin : main
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {16'd0, load, loadval, miss_trigger, round, busy, done}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_quiet", {20'd0, load, round, busy, done}, 32'd0);
        end
        play_game(0, 1'b1, 1'b0);
        play_game(1, 1'b0, 1'b0);
        play_game(3, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) play_game(2, 1'b0, 1'b0);
        play_game(0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_after_reset", {20'd0, load, round, busy, done}, 32'd0);
        end
        play_game(2, 1'b0, 1'b0);
        check("pattern_all_ones", 32'(pat_a), 32'h03);
        check("pattern_zero_idx6", 32'(pat_b), 32'h02);
        check("pattern_three_bits", 32'(pat_c), 32'h05);
        check("pattern_zero_idx7", 32'(pat_d), 32'h04);
        check("final_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
